ydemux2_dispatch: RTL and testbench

- Two-way demultiplexer: the counterpart of the 2:1 mux. One input stream is steered to one of two output streams under control of a per-word select bit.
- Each output port has a 2-entry FIFO, so one stalled consumer does not corrupt words that have already been accepted.
- Sits between a single producer (e.g. a decode/issue stage) and two consumers (e.g. ALU path and memory path).
- Valid/ready handshake on all three ports.

---
 rtl/ydemux2_dispatch_pkg.sv | 13 +
 rtl/ydemux2_dispatch_fifo2.sv | 73 +++++++
 rtl/ydemux2_dispatch.sv | 74 +++++++
 tb/tb_ydemux2_dispatch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ydemux2_dispatch_pkg.sv
// Shared defaults and FIFO occupancy encoding for the 1:2 dispatch demux.
package ydemux2_dispatch_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNTW_DEF  = 8;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'b00,
        FIFO_ONE   = 2'b01,
        FIFO_FULL  = 2'b10
    } fifo_state_e;

endpackage

// File: rtl/ydemux2_dispatch_fifo2.sv
// Two-entry FIFO with a registered head word; head is what the consumer sees.
module ydemux_fifo2
    import ydemux2_dispatch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    fifo_state_e      state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             do_push, do_pop;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        // Guards keep the state legal even if a caller ignores full/valid.
        do_push = push & (state_q != FIFO_FULL);
        do_pop  = pop & (state_q != FIFO_EMPTY);
        case (state_q)
            FIFO_EMPTY: begin
                if (do_push) begin
                    head_d  = din;
                    state_d = FIFO_ONE;
                end
            end
            FIFO_ONE: begin
                case ({do_push, do_pop})
                    2'b10: begin
                        tail_d  = din;
                        state_d = FIFO_FULL;
                    end
                    2'b01: state_d = FIFO_EMPTY;
                    2'b11: head_d = din;
                    default: ;
                endcase
            end
            FIFO_FULL: begin
                if (do_pop) begin
                    head_d  = tail_q;
                    state_d = FIFO_ONE;
                end
            end
            default: state_d = FIFO_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIFO_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign full  = (state_q == FIFO_FULL);
    assign valid = (state_q != FIFO_EMPTY);
    assign head  = head_q;

endmodule

// File: rtl/ydemux2_dispatch.sv
// 1:2 demux: steers each input word to one of two buffered output ports by in_sel.
module ydemux2_dispatch
    import ydemux2_dispatch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1
);

    logic            full0, full1;
    logic            push0, push1;
    logic [CNTW-1:0] cnt0_q, cnt0_d;
    logic [CNTW-1:0] cnt1_q, cnt1_d;

    // Ready depends only on the target FIFO's fullness, never on consumer ready.
    assign in_ready = in_sel ? ~full1 : ~full0;
    assign push0    = in_valid & in_ready & ~in_sel;
    assign push1    = in_valid & in_ready & in_sel;

    ydemux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .pop   (out0_valid & out0_ready),
        .din   (in_data),
        .full  (full0),
        .valid (out0_valid),
        .head  (out0_data)
    );

    ydemux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .pop   (out1_valid & out1_ready),
        .din   (in_data),
        .full  (full1),
        .valid (out1_valid),
        .head  (out1_data)
    );

    always_comb begin
        cnt0_d = cnt0_q + CNTW'(push0);
        cnt1_d = cnt1_q + CNTW'(push1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_ydemux2_dispatch.sv
// Directed + randomized bench for ydemux2_dispatch against a queue-based reference model.
module tb_ydemux2_dispatch;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_sel;
    logic [31:0] in_data;
    logic        out0_valid, out0_ready, out1_valid, out1_ready;
    logic [31:0] out0_data, out1_data;
    logic [7:0]  cnt0, cnt1;

    int passed = 0;
    int total  = 0;

    // Reference model: one queue per port plus plain integer push counts.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          mc0 = 0;
    int          mc1 = 0;
    logic [31:0] obs0[$];
    logic [31:0] obs1[$];

    ydemux2_dispatch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic model_ready();
        return in_sel ? (q1.size() < 2) : (q0.size() < 2);
    endfunction

    // Apply inputs, let them settle, then compare every output with the model.
    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic r0, input logic r1);
        in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
        #2;
        chk("in_ready", in_ready, model_ready());
        chk("out0_valid", out0_valid, q0.size() > 0);
        chk("out1_valid", out1_valid, q1.size() > 0);
        if (q0.size() > 0) chk("out0_data", out0_data, q0[0]);
        if (q1.size() > 0) chk("out1_data", out1_data, q1[0]);
        chk("cnt0", cnt0, mc0 % 256);
        chk("cnt1", cnt1, mc1 % 256);
    endtask

    task automatic tick();
        logic pu, p0, p1;
        pu = in_valid && model_ready();
        p0 = (q0.size() > 0) && out0_ready;
        p1 = (q1.size() > 0) && out1_ready;
        if (out0_valid && out0_ready) obs0.push_back(out0_data);
        if (out1_valid && out1_ready) obs1.push_back(out1_data);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (pu) begin
            if (in_sel) begin q1.push_back(in_data); mc1++; end
            else        begin q0.push_back(in_data); mc0++; end
        end
        #1;
    endtask

    task automatic step(input logic v, input logic s, input logic [31:0] d,
                        input logic r0, input logic r1);
        drive(v, s, d, r0, r1);
        tick();
    endtask

    // Fill both FIFOs, then pulse reset mid-cycle and check it acts immediately.
    task automatic reset_full();
        step(1, 0, 32'hA0, 0, 0);
        step(1, 0, 32'hA1, 0, 0);
        step(1, 1, 32'hB0, 0, 0);
        step(1, 1, 32'hB1, 0, 0);
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_out0_valid", out0_valid, 1'b0);
        chk("rst_out1_valid", out1_valid, 1'b0);
        chk("rst_out0_data", out0_data, 32'h0);
        chk("rst_out1_data", out1_data, 32'h0);
        chk("rst_cnt0", cnt0, 8'h0);
        chk("rst_cnt1", cnt1, 8'h0);
        q0.delete(); q1.delete(); mc0 = 0; mc1 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk("rst_in_ready", in_ready, 1'b1);
        tick();
        drive(0, 1, 0, 0, 0);
        chk("rst_no_pulse0", out0_valid, 1'b0);
        chk("rst_no_pulse1", out1_valid, 1'b0);
        tick();
    endtask

    initial begin
        logic [31:0] e0[4];
        logic [31:0] e1[4];
        e0 = '{32'h1, 32'h3, 32'h5, 32'h7};
        e1 = '{32'h2, 32'h4, 32'h6, 32'h8};
        rst_n = 1'b0;
        in_valid = 0; in_sel = 0; in_data = 0; out0_ready = 0; out1_ready = 0;
        #3;
        chk("init_out0_valid", out0_valid, 1'b0);
        chk("init_out1_valid", out1_valid, 1'b0);
        chk("init_out0_data", out0_data, 32'h0);
        chk("init_cnt0", cnt0, 8'h0);
        chk("init_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic route with one-cycle latency
        drive(1, 0, 32'hDEADBEEF, 1, 1);
        chk("basic_in_ready", in_ready, 1'b1);
        chk("basic_no_bypass", out0_valid, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("basic_out0_valid", out0_valid, 1'b1);
        chk("basic_out0_data", out0_data, 32'hDEADBEEF);
        chk("basic_out1_valid", out1_valid, 1'b0);
        chk("basic_cnt0", cnt0, 8'd1);
        step(0, 0, 0, 1, 1);

        // Backpressure on port 0 must not block port 1
        step(1, 0, 32'h11, 0, 1);
        step(1, 0, 32'h22, 0, 1);
        drive(1, 0, 32'h33, 0, 1);
        chk("bp_full_ready", in_ready, 1'b0);
        tick();
        drive(1, 1, 32'h44, 0, 1);
        chk("bp_iso_ready", in_ready, 1'b1);
        tick();
        drive(0, 0, 0, 1, 1);
        chk("bp_out1_data", out1_data, 32'h44);
        chk("bp_head_11", out0_data, 32'h11);
        tick();
        drive(0, 0, 0, 1, 1);
        chk("bp_head_22", out0_data, 32'h22);
        tick();
        drive(0, 0, 0, 1, 1);
        chk("bp_drained", out0_valid, 1'b0);
        tick();

        // Full port with a simultaneous pop still refuses the push
        step(1, 1, 32'h55, 1, 0);
        step(1, 1, 32'h66, 1, 0);
        drive(1, 1, 32'h77, 1, 1);
        chk("fp_ready_low", in_ready, 1'b0);
        tick();
        drive(1, 1, 32'h77, 1, 1);
        chk("fp_ready_high", in_ready, 1'b1);
        chk("fp_head_66", out1_data, 32'h66);
        tick();
        drive(0, 0, 0, 1, 1);
        chk("fp_head_77", out1_data, 32'h77);
        tick();
        step(0, 0, 0, 1, 1);

        reset_full();

        // Interleaved routing
        obs0.delete(); obs1.delete();
        for (int i = 1; i <= 8; i++) step(1, ~i[0], 32'(i), 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("ilv_cnt0", cnt0, 8'd4);
        chk("ilv_cnt1", cnt1, 8'd4);
        chk("ilv_n0", obs0.size(), 4);
        chk("ilv_n1", obs1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("ilv_p0", obs0[i], e0[i]);
            chk("ilv_p1", obs1[i], e1[i]);
        end

        // Counter wrap on port 0; port 1 count must stay put
        reset_full();
        for (int i = 0; i < 3; i++) step(1, 1, 32'(i), 1, 1);
        for (int i = 0; i < 256; i++) step(1, 0, 32'(i + 100), 1, 1);
        drive(0, 0, 0, 1, 1);
        chk("wrap_cnt0", cnt0, 8'd0);
        chk("wrap_cnt1", cnt1, 8'd3);
        tick();

        // Randomized traffic with random consumer stalls
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 1);
        chk("final_empty0", out0_valid, 1'b0);
        chk("final_empty1", out1_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
